// File: rtl/symbol_gen.sv
// symbol_gen -- serial symbol transmitter.
//
// Each accepted symbol (level, length) is driven on tx_out for exactly `length`
// clock cycles. A one-entry pending register sits behind the active symbol so
// consecutive symbols can run back-to-back with no idle gap.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   sym_vld/rdy   request handshake; transfer when sym_vld & sym_rdy
//   sym_lvl       level to drive for the symbol
//   sym_len       symbol length in cycles (LEN_W bits, unsigned)
//   sym_last      symbol ends a frame
//   tx_out        registered serial line output (IDLE_LVL when idle)
//   tx_busy       a symbol is being driven
//   sym_done      pulse on the final cycle of every symbol
//   frame_done    pulse on the final cycle of a symbol with sym_last=1
//   len_err       pulse the cycle after accepting a symbol shorter than MIN_LEN
//   udr_err       pulse in the first idle cycle after a non-last symbol ran dry
module symbol_gen #(
  parameter int   LEN_W       = 16,
  parameter logic IDLE_LVL    = 1'b1,
  parameter int   MIN_LEN     = 1,
  parameter int   END_OF_LIST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_vld,
  output logic             sym_rdy,
  input  logic             sym_lvl,
  input  logic [LEN_W-1:0] sym_len,
  input  logic             sym_last,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             sym_done,
  output logic             frame_done,
  output logic             len_err,
  output logic             udr_err
);

  // A zero-length symbol would never reach its final cycle.
  if (MIN_LEN < 1 || END_OF_LIST < 0) begin : g_param_chk
    $error("symbol_gen: MIN_LEN must be >= 1");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             tx_out_q;
  logic             act_last_q;
  logic             pend_vld_q;
  logic             pend_lvl_q;
  logic [LEN_W-1:0] pend_len_q;
  logic             pend_last_q;
  logic             sym_rdy_q;
  logic             len_err_q;
  logic             udr_err_q;

  logic acc, len_ok, take, last_cyc, pend_fill;

  assign acc       = sym_vld & sym_rdy_q;
  assign len_ok    = sym_len >= LEN_W'(MIN_LEN);
  assign take      = acc & len_ok;              // short symbols are dropped here
  assign last_cyc  = (state_q == SEND) && (cnt_q == LEN_W'(1));
  assign pend_fill = (state_q == SEND) && !last_cyc && take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_out_q    <= IDLE_LVL;
      act_last_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_lvl_q  <= 1'b0;
      pend_len_q  <= '0;
      pend_last_q <= 1'b0;
      sym_rdy_q   <= 1'b1;
      len_err_q   <= 1'b0;
      udr_err_q   <= 1'b0;
    end else begin
      len_err_q <= acc & ~len_ok;
      udr_err_q <= 1'b0;
      // Ready drops as the pending slot fills and stays low for one extra cycle
      // after it drains, so it never reads high while the slot is occupied.
      sym_rdy_q <= ~(pend_vld_q | pend_fill);
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q    <= SEND;
            cnt_q      <= sym_len;
            tx_out_q   <= sym_lvl;
            act_last_q <= sym_last;
          end
        end
        SEND: begin
          if (last_cyc) begin
            if (pend_vld_q) begin
              cnt_q      <= pend_len_q;
              tx_out_q   <= pend_lvl_q;
              act_last_q <= pend_last_q;
              pend_vld_q <= 1'b0;
            end else if (take) begin
              cnt_q      <= sym_len;
              tx_out_q   <= sym_lvl;
              act_last_q <= sym_last;
            end else begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              tx_out_q  <= IDLE_LVL;
              udr_err_q <= ~act_last_q;
            end
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (take) begin
              pend_vld_q  <= 1'b1;
              pend_lvl_q  <= sym_lvl;
              pend_len_q  <= sym_len;
              pend_last_q <= sym_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sym_rdy    = sym_rdy_q;
  assign tx_out     = tx_out_q;
  assign tx_busy    = (state_q == SEND);
  assign sym_done   = last_cyc;
  assign frame_done = last_cyc & act_last_q;
  assign len_err    = len_err_q;
  assign udr_err    = udr_err_q;

endmodule

// File: tb/tb_symbol_gen.sv
module tb_symbol_gen;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        sym_vld = 1'b0, sym_lvl = 1'b0, sym_last = 1'b0;
  logic [15:0] sym_len = '0;
  logic        sym_rdy, tx_out, tx_busy, sym_done, frame_done, len_err, udr_err;

  symbol_gen #(.LEN_W(16), .IDLE_LVL(1'b1), .MIN_LEN(1), .END_OF_LIST(1)) dut (
    .clk(clk), .rst_n(rst_n), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .sym_lvl(sym_lvl), .sym_len(sym_len), .sym_last(sym_last),
    .tx_out(tx_out), .tx_busy(tx_busy), .sym_done(sym_done),
    .frame_done(frame_done), .len_err(len_err), .udr_err(udr_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic lvl; int len; logic last; } exp_t;
  exp_t sbq[$];
  int   tests = 0, fails = 0, run_len = 0;
  bit   lvl_bad = 1'b0;

  // Scoreboard: every sym_done pops the oldest expected symbol and checks
  // its measured length, level and frame flag.
  task automatic monitor();
    if (tx_busy) begin
      run_len++;
      if (sbq.size() > 0 && tx_out !== sbq[0].lvl) lvl_bad = 1'b1;
    end
    if (sym_done) begin
      exp_t e;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_done: got sym_done=1, required no symbol outstanding");
      end else begin
        e = sbq.pop_front();
        if (run_len !== e.len || lvl_bad || frame_done !== e.last) begin
          fails++;
          $display("FAIL sb_symbol: got len=%0d lvl_err=%0d frame_done=%b, required len=%0d lvl=%b frame_done=%b",
                   run_len, lvl_bad, frame_done, e.len, e.lvl, e.last);
        end
      end
      run_len = 0;
      lvl_bad = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  // Drives one request until accepted; on return the bench sits in the cycle
  // after the transfer.
  task automatic send(input logic l, input int n, input logic last);
    bit acc = 1'b0;
    sym_vld = 1'b1; sym_lvl = l; sym_len = n[15:0]; sym_last = last;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = sym_rdy;
      if (acc && n >= 1) sbq.push_back('{lvl: l, len: n, last: last});
      tick();
    end
    sym_vld = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: got sym_rdy=0 for 200 cycles, required acceptance");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (tx_busy === 1'b1 && n < 500) begin n++; tick(); end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got tx_busy=1 after 500 cycles, required idle");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({tx_out, sym_rdy, tx_busy, sym_done, frame_done, len_err, udr_err} !== 7'b1100000) begin
      fails++;
      $display("FAIL reset_state: got %b, required 1100000",
               {tx_out, sym_rdy, tx_busy, sym_done, frame_done, len_err, udr_err});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    send(1'b0, 3, 1'b1);
    tests++;
    if (tx_out !== 1'b0 || tx_busy !== 1'b1) begin
      fails++; $display("FAIL single_start: got tx_out=%b busy=%b, required 0 1", tx_out, tx_busy);
    end
    tick(); tick();
    tests++;
    if (sym_done !== 1'b1 || frame_done !== 1'b1 || tx_out !== 1'b0) begin
      fails++;
      $display("FAIL single_final: got done=%b frame=%b tx=%b, required 1 1 0", sym_done, frame_done, tx_out);
    end
    tick();
    tests++;
    if (tx_out !== 1'b1 || udr_err !== 1'b0 || tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL single_end: got tx=%b udr=%b busy=%b, required 1 0 0", tx_out, udr_err, tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq;
    send(1'b0, 2, 1'b0);
    seq[5] = tx_out;
    send(1'b1, 4, 1'b1);
    seq[4] = tx_out;
    tests++;
    if (sym_rdy !== 1'b0 || sym_done !== 1'b1) begin
      fails++; $display("FAIL b2b_first_final: got rdy=%b done=%b, required 0 1", sym_rdy, sym_done);
    end
    tick(); seq[3] = tx_out;
    tests++;
    if (sym_rdy !== 1'b0) begin
      fails++; $display("FAIL b2b_rdy_hold: got rdy=%b, required 0", sym_rdy);
    end
    tick(); seq[2] = tx_out;
    tick(); seq[1] = tx_out;
    tick(); seq[0] = tx_out;
    tests++;
    if (sym_done !== 1'b1 || frame_done !== 1'b1) begin
      fails++; $display("FAIL b2b_second_final: got done=%b frame=%b, required 1 1", sym_done, frame_done);
    end
    tests++;
    if (seq !== 6'b001111) begin
      fails++; $display("FAIL b2b_sequence: got %b, required 001111", seq);
    end
    tick();
    tests++;
    if (tx_out !== 1'b1 || udr_err !== 1'b0) begin
      fails++; $display("FAIL b2b_end: got tx=%b udr=%b, required 1 0", tx_out, udr_err);
    end
  endtask

  task automatic test_len_err();
    send(1'b0, 0, 1'b1);
    tests++;
    if (len_err !== 1'b1 || tx_out !== 1'b1 || sym_done !== 1'b0 || frame_done !== 1'b0 || tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL len_err_idle: got err=%b tx=%b done=%b frame=%b busy=%b, required 1 1 0 0 0",
               len_err, tx_out, sym_done, frame_done, tx_busy);
    end
    tick();
    tests++;
    if (len_err !== 1'b0 || tx_out !== 1'b1) begin
      fails++; $display("FAIL len_err_once: got err=%b tx=%b, required 0 1", len_err, tx_out);
    end
    // A zero-length request during a running symbol must not take the pending slot.
    send(1'b0, 5, 1'b1);
    send(1'b1, 0, 1'b0);
    tests++;
    if (len_err !== 1'b1 || sym_rdy !== 1'b1 || tx_out !== 1'b0) begin
      fails++;
      $display("FAIL len_err_send: got err=%b rdy=%b tx=%b, required 1 1 0", len_err, sym_rdy, tx_out);
    end
    drain();
    tests++;
    if (tx_out !== 1'b1 || udr_err !== 1'b0) begin
      fails++; $display("FAIL len_err_drain: got tx=%b udr=%b, required 1 0", tx_out, udr_err);
    end
  endtask

  task automatic test_underrun();
    send(1'b0, 2, 1'b0);
    tick();
    tests++;
    if (sym_done !== 1'b1 || frame_done !== 1'b0) begin
      fails++; $display("FAIL udr_final: got done=%b frame=%b, required 1 0", sym_done, frame_done);
    end
    tick();
    tests++;
    if (tx_out !== 1'b1 || udr_err !== 1'b1) begin
      fails++; $display("FAIL udr_pulse: got tx=%b udr=%b, required 1 1", tx_out, udr_err);
    end
    tick();
    tests++;
    if (udr_err !== 1'b0) begin
      fails++; $display("FAIL udr_once: got udr=%b, required 0", udr_err);
    end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 20; i++)
      send(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), (i == 19));
    drain();
    tests++;
    if (sbq.size() != 0) begin
      fails++; $display("FAIL stream_leftover: got %0d outstanding, required 0", sbq.size());
    end
  endtask

  task automatic test_max_len();
    int n = 0;
    send(1'b0, 65535, 1'b1);
    while (tx_out === 1'b0 && n < 70000) begin n++; tick(); end
    tests++;
    if (n != 65535) begin
      fails++; $display("FAIL max_len: got %0d low cycles, required 65535", n);
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    send(1'b0, 300, 1'b1);
    send(1'b1, 5, 1'b0);
    repeat (98) tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || sym_rdy !== 1'b1 || sym_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_async: got tx=%b busy=%b rdy=%b done=%b, required 1 0 1 0",
               tx_out, tx_busy, sym_rdy, sym_done);
    end
    sbq.delete();
    run_len = 0;
    lvl_bad = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL reset_mid_pending_lost: got line activity after reset, required idle tx=1");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    tick();
    test_back_to_back();
    test_len_err();
    test_underrun();
    test_random_stream();
    test_max_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
